// File: rtl/modem_pkg.sv
// Shared modem definitions: the transmit/receive FSM state encoding and the
// reflected-Gray encoder used by both the transmitter and the receive-side decoder.
package modem_pkg;

  // Frame sequencer states: IDLE waits for a symbol, SEND emits the marker bit
  // and payload, STOP emits the idle-level stop bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    STOP = 2'd2
  } state_t;

  // Widest payload the shared helpers support.
  localparam int MODEM_MAX_W = 16;

  // Reflected binary Gray code: g = d ^ (d >> 1).
  function automatic logic [MODEM_MAX_W-1:0] gray_enc(input logic [MODEM_MAX_W-1:0] d);
    return d ^ (d >> 1);
  endfunction

endpackage

// File: rtl/serial_code_tx_if.sv
// Symbol input bus of the serial code-word transmitter.
//
// Handshake: a transfer happens on every rising clk edge where s_valid and
// s_ready are both 1. The master holds s_valid, s_data, gray_en and msb_first
// stable until that edge; s_valid may be raised without waiting for s_ready.
// s_ready never depends combinationally on s_valid.
interface serial_code_tx_if #(
  parameter int DATA_W = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              gray_en;
  logic              msb_first;

  modport master (
    output s_valid, s_data, gray_en, msb_first,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, gray_en, msb_first,
    output s_ready
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-rate tick generator in the clk domain: emits a one-cycle tick every
// BAUD_DIV clocks, restarting its count whenever clear_i is high.
module baud_tick_gen #(
  parameter int BAUD_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear restarts the period so the following bit is a full one.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_code_tx.sv
// Serial code-word transmitter: accepts a symbol, encodes it as binary or
// Gray (or the all-ones escape for out-of-range values), and sends
// marker bit + payload + stop bits on dout, one bit per BAUD_DIV clocks.
module serial_code_tx
  import modem_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_VAL   = 9,
  parameter int BAUD_DIV  = 500000,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_code_tx_if.slave   s,
  output logic              dout,
  output logic              busy,
  output logic              frame_done,
  output logic              range_err,
  output state_t            state_dbg
);

  localparam int BCW = $clog2(DATA_W + STOP_BITS + 1);
  localparam logic [BCW-1:0] BIT_PAYLOAD_LAST = BCW'(DATA_W);
  localparam logic [BCW-1:0] BIT_FRAME_LAST   = BCW'(DATA_W + STOP_BITS);

  state_t            state_q;
  logic              s_ready_q;
  logic              dout_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              range_err_q;
  logic [DATA_W-1:0] sh_q;
  logic              msb_q;
  logic [BCW-1:0]    bit_cnt_q;

  logic                   accept;
  logic                   tick;
  logic                   esc_d;
  logic [MODEM_MAX_W-1:0] gray_full;
  logic [DATA_W-1:0]      payload_d;
  logic                   unused_gray_bits;

  assign accept = s.s_valid && s_ready_q;

  // Bit-period timing restarts at acceptance so the marker bit is a full period.
  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // Payload as it will be latched on acceptance: escape, Gray or binary.
  always_comb begin
    gray_full = gray_enc(MODEM_MAX_W'(s.s_data));
    esc_d     = (32'(s.s_data) > 32'(MAX_VAL));
    payload_d = s.gray_en ? gray_full[DATA_W-1:0] : s.s_data;
    if (esc_d) begin
      payload_d = '1;
    end
  end

  // Upper Gray bits beyond DATA_W are don't-care for narrow payloads.
  assign unused_gray_bits = ^gray_full;

  // Frame sequencer with registered line, status and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
      sh_q         <= '0;
      msb_q        <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SEND;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b1;
            dout_q      <= 1'b1;
            sh_q        <= payload_d;
            msb_q       <= s.msb_first;
            bit_cnt_q   <= '0;
            range_err_q <= esc_d;
          end else begin
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            dout_q    <= 1'b0;
          end
        end
        SEND: begin
          if (tick) begin
            if (bit_cnt_q == BIT_PAYLOAD_LAST) begin
              if (STOP_BITS == 0) begin
                state_q      <= IDLE;
                s_ready_q    <= 1'b1;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b1;
                bit_cnt_q    <= '0;
              end else begin
                state_q   <= STOP;
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
              dout_q <= 1'b0;
            end else begin
              dout_q    <= msb_q ? sh_q[DATA_W-1] : sh_q[0];
              sh_q      <= msb_q ? (sh_q << 1) : (sh_q >> 1);
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          dout_q <= 1'b0;
          if (tick) begin
            if (bit_cnt_q == BIT_FRAME_LAST) begin
              state_q      <= IDLE;
              s_ready_q    <= 1'b1;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          dout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s.s_ready  = s_ready_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign range_err  = range_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_code_tx.sv
// Directed bench for serial_code_tx with BAUD_DIV=4, DATA_W=4, MAX_VAL=9,
// STOP_BITS=1 (frame = 6 bits x 4 cycles = 24 cycles, frame_done at T+25).
module tb_serial_code_tx;
  import modem_pkg::*;

  localparam int DATA_W    = 4;
  localparam int MAX_VAL   = 9;
  localparam int BAUD_DIV  = 4;
  localparam int STOP_BITS = 1;

  // Traces index 0 = cycle T+1 ... index 24 = cycle T+25.
  localparam logic [24:0] EXP_BUSY = 25'h0FF_FFFF;
  localparam logic [24:0] EXP_LAST = 25'h100_0000;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   dout, busy, frame_done, range_err;
  state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  serial_code_tx_if #(.DATA_W(DATA_W)) sif ();

  serial_code_tx #(
    .DATA_W    (DATA_W),
    .MAX_VAL   (MAX_VAL),
    .BAUD_DIV  (BAUD_DIV),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sif),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .range_err  (range_err),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Expand 6 frame bits (bit 5 sent first) into the 25-cycle dout trace.
  function automatic logic [24:0] expand(input logic [5:0] bits);
    logic [24:0] r;
    r = '0;
    for (int i = 0; i < 24; i++) r[i] = bits[5 - i / 4];
    return r;
  endfunction

  // Golden frame: marker, payload in chosen order, one stop bit.
  function automatic logic [5:0] model_frame(input logic [3:0] d, input logic g, input logic m);
    logic [3:0] p;
    logic [5:0] b;
    if (d > 4'd9) p = 4'hF;
    else if (g)   p = d ^ (d >> 1);
    else          p = d;
    b = '0;
    b[5] = 1'b1;
    for (int k = 0; k < 4; k++) b[4 - k] = m ? p[3 - k] : p[k];
    return b;
  endfunction

  task automatic drive_sym(input logic [3:0] d, input logic g, input logic m, input logic v);
    sif.s_data    = d;
    sif.gray_en   = g;
    sif.msb_first = m;
    sif.s_valid   = v;
  endtask

  // Wait (bounded) at negedges until s_ready is high.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sif.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Record 25 cycles of outputs starting at cycle T+1.
  task automatic capture_frame(output logic [24:0] d_tr, output logic [24:0] b_tr,
                               output logic [24:0] r_tr, output logic [24:0] f_tr,
                               output logic [24:0] e_tr);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      d_tr[i] = dout;
      b_tr[i] = busy;
      r_tr[i] = sif.s_ready;
      f_tr[i] = frame_done;
      e_tr[i] = range_err;
    end
  endtask

  task automatic test_reset();
    drive_sym(4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sif.s_ready, dout, busy, frame_done, range_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000",
               {sif.s_ready, dout, busy, frame_done, range_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (sif.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b required 0", sif.s_ready);
    end
    @(negedge clk);
    n_checks++;
    if (sif.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge: got %b required 1", sif.s_ready);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE);
    end
  endtask

  task automatic test_gray_msb();
    logic [24:0] d_tr, b_tr, r_tr, f_tr, e_tr;
    bit ok;
    drive_sym(4'd9, 1'b1, 1'b1, 1'b1);
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL gray_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    capture_frame(d_tr, b_tr, r_tr, f_tr, e_tr);
    n_checks++;
    if (d_tr !== expand(6'b111010)) begin
      n_fail++;
      $display("FAIL gray_dout: got %h required %h", d_tr, expand(6'b111010));
    end
    n_checks++;
    if (b_tr !== EXP_BUSY) begin
      n_fail++;
      $display("FAIL gray_busy: got %h required %h", b_tr, EXP_BUSY);
    end
    n_checks++;
    if (r_tr !== EXP_LAST) begin
      n_fail++;
      $display("FAIL gray_ready: got %h required %h", r_tr, EXP_LAST);
    end
    n_checks++;
    if (f_tr !== EXP_LAST) begin
      n_fail++;
      $display("FAIL gray_frame_done: got %h required %h", f_tr, EXP_LAST);
    end
    n_checks++;
    if (e_tr !== 25'h0) begin
      n_fail++;
      $display("FAIL gray_range_err: got %h required 0", e_tr);
    end
  endtask

  task automatic test_binary();
    logic [3:0]  vd [2] = '{4'd9, 4'd3};
    logic        vm [2] = '{1'b1, 1'b0};
    logic [5:0]  vb [2] = '{6'b110010, 6'b111000};
    logic [24:0] d_tr, b_tr, r_tr, f_tr, e_tr;
    bit ok;
    for (int v = 0; v < 2; v++) begin
      drive_sym(vd[v], 1'b0, vm[v], 1'b1);
      wait_ready(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL binary_ready_timeout[%0d]: got 0 required 1", v);
      end
      @(posedge clk);
      #1;
      sif.s_valid = 1'b0;
      capture_frame(d_tr, b_tr, r_tr, f_tr, e_tr);
      n_checks++;
      if (d_tr !== expand(vb[v])) begin
        n_fail++;
        $display("FAIL binary_dout[%0d]: got %h required %h", v, d_tr, expand(vb[v]));
      end
      n_checks++;
      if (f_tr !== EXP_LAST) begin
        n_fail++;
        $display("FAIL binary_frame_done[%0d]: got %h required %h", v, f_tr, EXP_LAST);
      end
    end
  endtask

  task automatic test_escape();
    logic [24:0] d_tr, b_tr, r_tr, f_tr, e_tr;
    bit ok;
    drive_sym(4'd12, 1'b1, 1'b1, 1'b1);
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL escape_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    capture_frame(d_tr, b_tr, r_tr, f_tr, e_tr);
    n_checks++;
    if (d_tr !== expand(6'b111110)) begin
      n_fail++;
      $display("FAIL escape_dout: got %h required %h", d_tr, expand(6'b111110));
    end
    n_checks++;
    if (e_tr !== 25'h1) begin
      n_fail++;
      $display("FAIL escape_range_err: got %h required 0000001", e_tr);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  vd [3] = '{4'd5, 4'd10, 4'd6};
    logic        vg [3] = '{1'b1, 1'b0, 1'b0};
    logic        vm [3] = '{1'b0, 1'b1, 1'b1};
    logic [5:0]  vb [3] = '{6'b111100, 6'b111110, 6'b101100};
    logic [24:0] d_tr, b_tr, r_tr, f_tr, e_tr;
    bit ok;
    drive_sym(vd[0], vg[0], vm[0], 1'b1);
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_ready_timeout: got 0 required 1");
    end
    for (int f = 0; f < 3; f++) begin
      @(posedge clk);
      #1;
      if (f < 2) drive_sym(vd[f+1], vg[f+1], vm[f+1], 1'b1);
      else       sif.s_valid = 1'b0;
      capture_frame(d_tr, b_tr, r_tr, f_tr, e_tr);
      n_checks++;
      if (d_tr !== expand(vb[f])) begin
        n_fail++;
        $display("FAIL b2b_dout[%0d]: got %h required %h", f, d_tr, expand(vb[f]));
      end
      n_checks++;
      if (d_tr !== expand(model_frame(vd[f], vg[f], vm[f]))) begin
        n_fail++;
        $display("FAIL b2b_model[%0d]: got %h required %h", f, d_tr,
                 expand(model_frame(vd[f], vg[f], vm[f])));
      end
      n_checks++;
      if (r_tr !== EXP_LAST) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %h required %h", f, r_tr, EXP_LAST);
      end
      n_checks++;
      if (e_tr !== ((f == 1) ? 25'h1 : 25'h0)) begin
        n_fail++;
        $display("FAIL b2b_range_err[%0d]: got %h", f, e_tr);
      end
    end
  endtask

  task automatic test_input_toggle();
    logic [24:0] d_tr, r_tr;
    logic [5:0]  exp_bits;
    bit ok;
    exp_bits = model_frame(4'd6, 1'b1, 1'b1);
    drive_sym(4'd6, 1'b1, 1'b1, 1'b1);
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL toggle_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
    d_tr = '0;
    r_tr = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d_tr[i] = dout;
      r_tr[i] = sif.s_ready;
      drive_sym(4'(sif.s_data + 4'd7), ~sif.gray_en, ~sif.msb_first, (i < 23));
    end
    n_checks++;
    if (d_tr !== expand(6'b101010)) begin
      n_fail++;
      $display("FAIL toggle_dout: got %h required %h", d_tr, expand(6'b101010));
    end
    n_checks++;
    if (d_tr !== expand(exp_bits)) begin
      n_fail++;
      $display("FAIL toggle_model: got %h required %h", d_tr, expand(exp_bits));
    end
    n_checks++;
    if (r_tr !== 25'h0) begin
      n_fail++;
      $display("FAIL toggle_ready_while_busy: got %h required 0", r_tr);
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_frame_done: got %b required 1", frame_done);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, dout, sif.s_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL toggle_no_extra_accept: got %b required 001", {busy, dout, sif.s_ready});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [24:0] d_tr, b_tr, r_tr, f_tr, e_tr;
    int fd_count;
    bit ok;
    drive_sym(4'd9, 1'b1, 1'b1, 1'b1);
    wait_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_mid_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({dout, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got %b required 11", {dout, busy});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout, busy, sif.s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %b required 000", {dout, busy, sif.s_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sif.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready_after: got %b required 1", sif.s_ready);
    end
    fd_count = 0;
    for (int i = 0; i < 30; i++) begin
      if (frame_done === 1'b1) fd_count++;
      @(negedge clk);
    end
    n_checks++;
    if (fd_count != 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_frame_done: got %0d required 0", fd_count);
    end
    drive_sym(4'd3, 1'b0, 1'b0, 1'b1);
    wait_ready(ok);
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    capture_frame(d_tr, b_tr, r_tr, f_tr, e_tr);
    n_checks++;
    if (d_tr !== expand(6'b111000)) begin
      n_fail++;
      $display("FAIL rst_mid_next_frame: got %h required %h", d_tr, expand(6'b111000));
    end
    n_checks++;
    if (f_tr !== EXP_LAST) begin
      n_fail++;
      $display("FAIL rst_mid_next_done: got %h required %h", f_tr, EXP_LAST);
    end
  endtask

  // Scenario sequence and final report.
  initial begin
    test_reset();
    test_gray_msb();
    test_binary();
    test_escape();
    test_back_to_back();
    test_input_toggle();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
